piso_serial_ctrl: RTL and testbench
===================================

# piso_serial_ctrl

Sequencing controller for the 4-bit-class PISO shift datapath, generalised to WIDTH bits. It accepts a parallel word over a valid/ready handshake and captures it into an internal shift register. It then shifts the word out LSB-first, holding each bit for DIV clock cycles, with framing, bit-strobe and completion status. It sits between a word-producing block (FIFO, register file) and a single-wire serial sink.

## Interface
- WIDTH, 8: data word width; legal range WIDTH ≥ 2.
- DIV, 1: clock cycles per serial bit; legal range DIV ≥ 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word; sampled only on handshake.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept; equals (state == IDLE).
- serial_out  output  1  current serial bit, registered.
- frame  output  1  high while any frame bit (data or parity) is driven.
- bit_strobe  output  1  one-cycle pulse in the first cycle of each bit period.
- done  output  1  one-cycle pulse in the cycle after the last bit period ends.
- busy  output  1  high in SHIFT and PARITY states.

## Operation
- The state machine has three states:
  - IDLE → SHIFT on handshake (in_valid && in_ready).
  - SHIFT → PARITY after bit WIDTH-1 completes, when parity is compiled in.
  - SHIFT → IDLE after bit WIDTH-1 completes, when parity is compiled out.
  - PARITY → IDLE after its bit period.
- On handshake:
  - shift_reg ← in_data.
  - bit_cnt ← 0.
  - div_cnt ← 0.
  - Parity accumulator ← ^in_data.
- In SHIFT:
  - serial_out = shift_reg[0].
  - div_cnt counts 0..DIV-1.
  - At div_cnt == DIV-1, shift_reg shifts right with zero fill, bit_cnt increments and div_cnt wraps to 0.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is max(1, $clog2(DIV)) bits. Neither counter ever exceeds its terminal value.
- In_data changes after acceptance have no effect.
- In_valid while busy is ignored and is not queued; in_ready stays 0.
- When the frame ends:
  - serial_out returns to 0 in IDLE.
  - frame and busy drop.
  - done pulses for one cycle.
- in_ready is 1 in that same cycle, so a new word may be accepted in the done cycle.

## Timing
- Reset values:
  - state = IDLE.
  - serial_out = 0.
  - frame = 0, bit_strobe = 0, done = 0, busy = 0.
  - in_ready = 1, because it is combinational from state.
  - All counters and shift_reg = 0.
- Reset asserted mid-frame:
  - The frame is abandoned immediately and asynchronously.
  - No done pulse is issued.
  - After reset deasserts, the controller is in IDLE with in_ready = 1.
- Latency, with handshake at edge T0:
  - Bit 0 appears on serial_out after T0.
  - frame = 1 and bit_strobe = 1 in that same cycle.
- Bit k occupies cycles [T0 + k·DIV, T0 + (k+1)·DIV).
- Frame length is N = WIDTH·DIV cycles, or (WIDTH+1)·DIV with parity.
- done is high in cycle T0 + N, together with in_ready = 1, busy = 0 and frame = 0.
- Back-to-back throughput is one frame every N+1 cycles. There is one IDLE (done) cycle between frames, with serial_out = 0.
- bit_strobe coincides with div_cnt == 0 in SHIFT and PARITY states. For DIV = 1, bit_strobe is high on every frame cycle.

## Configuration
- Macro: PISO_SERIAL_PARITY_EN.
- Defined:
  - After data bit WIDTH-1, a PARITY state drives the even-parity bit (^in_data) for DIV cycles.
  - frame, busy and bit_strobe behave as for a data bit.
  - done follows the parity bit.
- Undefined:
  - No PARITY state and no parity logic.
  - SHIFT → IDLE directly after bit WIDTH-1.

## Test plan
- Reset, no stimulus:
  - Required: serial_out = 0, frame = 0, busy = 0, done = 0, in_ready = 1.
- WIDTH=8, DIV=1, parity off, in_data = 0xA5 accepted at T0:
  - Required: serial_out = 1,0,1,0,0,1,0,1 on cycles T0+0..7.
  - Required: bit_strobe high all 8 cycles; done = 1 at T0+8.
- WIDTH=8, DIV=3, in_data = 0x01:
  - Required: serial_out = 1 for 3 cycles, then 0 for 21 cycles.
  - Required: bit_strobe pulses every 3rd cycle (8 pulses); done at T0+24.
- Back-to-back, DIV=1: in_valid held high with 0xFF then 0x00:
  - Required: second handshake occurs in the done cycle T0+8.
  - Required: second frame starts at T0+9.
  - Required: in_valid asserted during busy with changing in_data does not alter the bits.
- Reset asserted at T0+4 of a 0xA5 frame:
  - Required: outputs are at reset values immediately and no done pulse occurs.
  - Required: a new 0x3C frame after reset serialises correctly.
- PISO_SERIAL_PARITY_EN defined, DIV=1:
  - Required: 0xA5 gives parity bit 0 at T0+8 and done at T0+9.
  - Required: 0x07 gives parity bit 1 at T0+8.

Source files
------------

// File: rtl/piso_serial_ctrl.sv
// -----------------------------------------------------------------------------
// piso_serial_ctrl
//
// Parallel-in / serial-out sequencing controller. A WIDTH-bit word is accepted
// over a valid/ready handshake, then shifted out LSB-first on serial_out, each
// bit held for DIV clock cycles. Framing (frame/busy), a per-bit strobe and a
// one-cycle completion pulse (done) accompany the serial stream.
//
// Optional feature macro: PISO_SERIAL_PARITY_EN
//   When defined, an even-parity bit (^word) is sent for DIV cycles after the
//   last data bit, and done follows the parity bit.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   DIV        clock cycles per serial bit (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    parallel word, sampled only on handshake
//   in_valid   producer has a word
//   in_ready   controller can accept (state is IDLE), combinational
//   serial_out current serial bit, registered, 0 when idle
//   frame      high while any frame bit (data or parity) is driven
//   bit_strobe one-cycle pulse in the first cycle of each bit period
//   done       one-cycle pulse in the cycle after the last bit period
//   busy       high while a frame is being sent
// -----------------------------------------------------------------------------
module piso_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             bit_strobe,
    output logic             done,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef PISO_SERIAL_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

`ifdef PISO_SERIAL_PARITY_EN
    // Even parity of a data word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [DW-1:0]    div_cnt_r, div_cnt_s;
`ifdef PISO_SERIAL_PARITY_EN
    logic             parity_r, parity_s;
`endif

    logic serial_out_r, frame_r, bit_strobe_r, done_r, busy_r;
    logic serial_s, frame_s, strobe_s, done_s;

    logic handshake_s;
    logic div_end_s;
    logic last_bit_s;

    assign handshake_s = in_valid && (state_r == ST_IDLE);
    assign div_end_s   = (div_cnt_r == DIV_LAST);
    assign last_bit_s  = (bit_cnt_r == BIT_LAST);

    // Next-state, shift register and bit/divider counter logic.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        div_cnt_s = div_cnt_r;
`ifdef PISO_SERIAL_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_s   = ST_SHIFT;
                    shift_s   = in_data;
                    bit_cnt_s = BIT_ZERO;
                    div_cnt_s = DIV_ZERO;
`ifdef PISO_SERIAL_PARITY_EN
                    parity_s  = even_parity(in_data);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_end_s) begin
                    div_cnt_s = DIV_ZERO;
                    shift_s   = {1'b0, shift_r[WIDTH-1:1]};
                    if (last_bit_s) begin
                        // Counter parks at zero instead of wrapping past its terminal value.
                        bit_cnt_s = BIT_ZERO;
`ifdef PISO_SERIAL_PARITY_EN
                        state_s   = ST_PARITY;
`else
                        state_s   = ST_IDLE;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIV_ONE;
                end
            end
`ifdef PISO_SERIAL_PARITY_EN
            ST_PARITY: begin
                if (div_end_s) begin
                    div_cnt_s = DIV_ZERO;
                    state_s   = ST_IDLE;
                end else begin
                    div_cnt_s = div_cnt_r + DIV_ONE;
                end
            end
`endif
            default: begin
                state_s   = ST_IDLE;
                shift_s   = '0;
                bit_cnt_s = BIT_ZERO;
                div_cnt_s = DIV_ZERO;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        serial_s = 1'b0;
        frame_s  = 1'b0;
        strobe_s = 1'b0;
        done_s   = 1'b0;
        if (state_s == ST_SHIFT) begin
            serial_s = shift_s[0];
            frame_s  = 1'b1;
        end
`ifdef PISO_SERIAL_PARITY_EN
        else if (state_s == ST_PARITY) begin
            serial_s = parity_s;
            frame_s  = 1'b1;
        end
`endif
        else begin
            serial_s = 1'b0;
            frame_s  = 1'b0;
        end
        strobe_s = frame_s && (div_cnt_s == DIV_ZERO);
        done_s   = (state_r != ST_IDLE) && (state_s == ST_IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= '0;
            bit_cnt_r    <= BIT_ZERO;
            div_cnt_r    <= DIV_ZERO;
`ifdef PISO_SERIAL_PARITY_EN
            parity_r     <= 1'b0;
`endif
            serial_out_r <= 1'b0;
            frame_r      <= 1'b0;
            bit_strobe_r <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            div_cnt_r    <= div_cnt_s;
`ifdef PISO_SERIAL_PARITY_EN
            parity_r     <= parity_s;
`endif
            serial_out_r <= serial_s;
            frame_r      <= frame_s;
            bit_strobe_r <= strobe_s;
            done_r       <= done_s;
            busy_r       <= frame_s;
        end
    end

    assign in_ready   = (state_r == ST_IDLE);
    assign serial_out = serial_out_r;
    assign frame      = frame_r;
    assign bit_strobe = bit_strobe_r;
    assign done       = done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_piso_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_serial_ctrl
//
// Self-checking bench for piso_serial_ctrl. Two instances (DIV=1 and DIV=3,
// WIDTH=8) share clock, reset and input stimulus. A frame-level reference
// model (word + cycle offset within the frame) predicts every output each
// cycle; directed sequences add constant-valued checks on top.
// -----------------------------------------------------------------------------
module tb_piso_serial_ctrl;

    localparam int WIDTH = 8;
`ifdef PISO_SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       rdy, sout, frm, stb, dn, bsy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per instance: m_cnt = cycle offset in frame, -1 when idle.
    int               m_cnt [2];
    logic [WIDTH-1:0] m_w   [2];
    logic             m_done[2];
    int               m_div [2];

    always #5 clk = ~clk;

    piso_serial_ctrl #(.WIDTH(WIDTH), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .serial_out(sout[0]), .frame(frm[0]),
        .bit_strobe(stb[0]), .done(dn[0]), .busy(bsy[0])
    );

    piso_serial_ctrl #(.WIDTH(WIDTH), .DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .serial_out(sout[1]), .frame(frm[1]),
        .bit_strobe(stb[1]), .done(dn[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int d);
        return (WIDTH + PAR) * d;
    endfunction

    // Expected {serial_out, frame, bit_strobe, done, busy, in_ready} for instance i.
    function automatic logic [5:0] model_out(input int i);
        int   k;
        logic b;
        if (m_cnt[i] >= 0) begin
            k = m_cnt[i] / m_div[i];
            b = (k < WIDTH) ? m_w[i][k] : ^m_w[i];
            return {b, 1'b1, (m_cnt[i] % m_div[i]) == 0, 1'b0, 1'b1, 1'b0};
        end
        return {1'b0, 1'b0, 1'b0, m_done[i], 1'b0, 1'b1};
    endfunction

    function automatic logic [5:0] dut_out(input int i);
        return {sout[i], frm[i], stb[i], dn[i], bsy[i], rdy[i]};
    endfunction

    task automatic model_step(input int i);
        if (rst) begin
            m_cnt[i]  = -1;
            m_done[i] = 1'b0;
        end else if (m_cnt[i] < 0) begin
            m_done[i] = 1'b0;
            if (in_valid) begin
                m_cnt[i] = 0;
                m_w[i]   = in_data;
            end
        end else begin
            m_cnt[i]++;
            if (m_cnt[i] == frame_len(m_div[i])) begin
                m_cnt[i]  = -1;
                m_done[i] = 1'b1;
            end
        end
    endtask

    // One clock: advance the model over the edge, then compare every output.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            check($sformatf("cycle div%0d", m_div[i]), 32'(dut_out(i)), 32'(model_out(i)));
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        in_valid = 1'b0;
        while (rdy != 2'b11 && guard < 200) begin
            tick();
            guard++;
        end
        check("idle wait", 32'(rdy), 32'h3);
    endtask

    logic [WIDTH-1:0] cap;
    int               cnt;
    int               ones;

    initial begin
        m_div[0] = 1;
        m_div[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = -1;
            m_done[i] = 1'b0;
            m_w[i]    = '0;
        end

        // Reset with no stimulus.
        #1 rst = 1'b1;
        #1;
        check("reset div1", 32'(dut_out(0)), 32'h01);
        check("reset div3", 32'(dut_out(1)), 32'h01);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 0xA5, LSB first.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        cap = '0;
        cnt = 0;
        for (int k = 0; k < WIDTH; k++) begin
            cap[k] = sout[0];
            cnt += int'(stb[0]);
            tick();
        end
        check("a5 bits", 32'(cap), 32'hA5);
        check("a5 strobes", 32'(cnt), 32'd8);
`ifdef PISO_SERIAL_PARITY_EN
        check("a5 parity bit", 32'(sout[0]), 32'd0);
        check("a5 parity frame", 32'(frm[0]), 32'd1);
        tick();
`endif
        check("a5 done", 32'(dn[0]), 32'd1);
        check("a5 ready in done", 32'(rdy[0]), 32'd1);
        wait_idle();

        // 0x01 at DIV=3: one high bit period then lows.
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        in_valid = 1'b0;
        ones = 0;
        cnt  = 0;
        for (int c = 0; c < frame_len(3); c++) begin
            if (c < 3) check("div3 first bit", 32'(sout[1]), 32'd1);
            ones += int'(sout[1]);
            cnt  += int'(stb[1]);
            tick();
        end
        check("div3 ones", 32'(ones), 32'(3 + 3 * PAR));
        check("div3 strobes", 32'(cnt), 32'(8 + PAR));
        check("div3 done", 32'(dn[1]), 32'd1);
        wait_idle();

        // Back-to-back at DIV=1 with in_valid held and in_data churning while busy.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        cap = '0;
        for (int k = 0; k < frame_len(1); k++) begin
            if (k < WIDTH) cap[k] = sout[0];
            in_data = WIDTH'($urandom);
            tick();
        end
        check("b2b first bits", 32'(cap), 32'hFF);
        check("b2b done", 32'(dn[0]), 32'd1);
        check("b2b ready in done", 32'(rdy[0]), 32'd1);
        in_data = 8'h00;
        tick();
        check("b2b second frame", 32'(frm[0]), 32'd1);
        check("b2b second bit0", 32'(sout[0]), 32'd0);
        in_valid = 1'b0;
        wait_idle();

        // Asynchronous reset at T0+4 of a 0xA5 frame.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2 rst = 1'b1;
        #1;
        check("midreset div1", 32'(dut_out(0)), 32'h01);
        check("midreset div3", 32'(dut_out(1)), 32'h01);
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = -1;
            m_done[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        cap = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cap[k] = sout[0];
            tick();
        end
        check("post reset bits", 32'(cap), 32'h3C);
        wait_idle();

`ifdef PISO_SERIAL_PARITY_EN
        // 0x07 has odd weight, so the parity bit is 1.
        in_valid = 1'b1;
        in_data  = 8'h07;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) tick();
        check("07 parity bit", 32'(sout[0]), 32'd1);
        tick();
        check("07 done", 32'(dn[0]), 32'd1);
        wait_idle();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = WIDTH'($urandom);
            tick();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
